// File: rtl/bpred_resolve.sv
// -----------------------------------------------------------------------------
// bpred_resolve
//
// Execute-side branch resolution and predictor-update generator.
//
// Compares the prediction carried down from fetch with the outcome computed
// in execute. On a mispredict it issues a one-cycle registered fetch redirect
// and RAS repair pulses, then ignores wrong-path branches for SQUASH_CYCLES
// cycles. Every resolved branch (hit or miss) is queued as an update record
// in a small FIFO that drains into the predictor whenever it is not stalled.
//
// Ports:
//   clk, reset_n                 clock (rising edge) / async active-low reset
//   ex_valid, ex_isBranch        execute slot holds a control transfer
//   ex_isCall, ex_isRet          call / return decode
//   ex_PC4                       PC+4 of the branch
//   ex_actual_dir/_target        resolved outcome
//   ex_pred_dir/_target          fetch-time prediction
//   ex_bimodal                   fetch-time bimodal info, carried unchanged
//   soin_bpredictor_stall        predictor cannot take an update this cycle
//   ex_stall                     backpressure to execute (update FIFO full)
//   redirect_valid/_PC           one-cycle fetch redirect
//   execute_missPred             RAS repair: mispredict pulse
//   execute_c_r_after_r          RAS repair: call/ret following a ret
//   execute_isCall               RAS repair: mispredicted branch was a call
//   execute_bpredictor_*         head record of the update FIFO
// -----------------------------------------------------------------------------
module bpred_resolve #(
   parameter int DEPTH         = 4,
   parameter int SQUASH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ex_valid,
   input  logic        ex_isBranch,
   input  logic        ex_isCall,
   input  logic        ex_isRet,
   input  logic [31:0] ex_PC4,
   input  logic        ex_actual_dir,
   input  logic [31:0] ex_actual_target,
   input  logic        ex_pred_dir,
   input  logic [31:0] ex_pred_target,
   input  logic [11:0] ex_bimodal,
   input  logic        soin_bpredictor_stall,
   output logic        ex_stall,
   output logic        redirect_valid,
   output logic [31:0] redirect_PC,
   output logic        execute_missPred,
   output logic        execute_c_r_after_r,
   output logic        execute_isCall,
   output logic        execute_bpredictor_update,
   output logic [31:0] execute_bpredictor_PC4,
   output logic [31:0] execute_bpredictor_target,
   output logic        execute_bpredictor_dir,
   output logic        execute_bpredictor_miss,
   output logic [11:0] execute_bpredictor_bimodal
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_SQUASH = 1'b1;

   localparam logic [3:0]  SQUASH_LOAD = 4'(SQUASH_CYCLES);
   localparam logic [AW:0] FULL_COUNT  = (AW + 1)'(DEPTH);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [0:0]    state_reg, state_next;
   logic [3:0]    squash_cnt_reg, squash_cnt_next;
   logic          last_was_ret_reg;

   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;

   // Update FIFO storage (no reset needed: only entries below count are read)
   logic [31:0]   mem_pc4     [DEPTH];
   logic [31:0]   mem_target  [DEPTH];
   logic          mem_dir     [DEPTH];
   logic          mem_miss    [DEPTH];
   logic [11:0]   mem_bimodal [DEPTH];

   // ------------------------------------------------------------------
   // Resolution
   // ------------------------------------------------------------------
   logic        empty;
   logic        full;
   logic        squashing;
   logic        resolve;
   logic        miss;
   logic        resolve_miss;
   logic [31:0] correct_pc;
   logic        push;
   logic        pop;

   assign empty     = (count_reg == '0);
   assign full      = (count_reg == FULL_COUNT);
   assign squashing = (state_reg == ST_SQUASH);
   assign ex_stall  = full;

   // A full FIFO holds the branch in execute, so it must not resolve yet:
   // otherwise it would redirect without ever producing its update record.
   assign resolve = ex_valid & ex_isBranch & ~squashing & ~full;

   // Target only matters when the branch is actually taken.
   assign miss = (ex_pred_dir != ex_actual_dir) |
                 (ex_actual_dir & (ex_pred_target != ex_actual_target));

   assign resolve_miss = resolve & miss;
   assign correct_pc   = ex_actual_dir ? ex_actual_target : ex_PC4;

   assign push = resolve;
   assign pop  = ~soin_bpredictor_stall & ~empty;

   // ------------------------------------------------------------------
   // Squash FSM
   // ------------------------------------------------------------------
   always_comb begin
      state_next      = state_reg;
      squash_cnt_next = squash_cnt_reg;
      case (state_reg)
         ST_IDLE: begin
            if (resolve_miss) begin
               state_next      = ST_SQUASH;
               squash_cnt_next = SQUASH_LOAD;
            end
         end
         ST_SQUASH: begin
            // Counter reaching zero on this edge ends the window, so the
            // branch presented in the following cycle resolves normally.
            if (squash_cnt_reg <= 4'd1) begin
               state_next      = ST_IDLE;
               squash_cnt_next = 4'd0;
            end else begin
               squash_cnt_next = squash_cnt_reg - 4'd1;
            end
         end
         default: begin
            state_next      = ST_IDLE;
            squash_cnt_next = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg        <= ST_IDLE;
         squash_cnt_reg   <= 4'd0;
         last_was_ret_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         squash_cnt_reg <= squash_cnt_next;
         if (resolve) begin
            last_was_ret_reg <= ex_isRet;
         end
      end
   end

   // ------------------------------------------------------------------
   // Redirect and RAS repair pulses (registered, self-clearing)
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         redirect_valid      <= 1'b0;
         redirect_PC         <= 32'd0;
         execute_missPred    <= 1'b0;
         execute_c_r_after_r <= 1'b0;
         execute_isCall      <= 1'b0;
      end else begin
         redirect_valid      <= resolve_miss;
         redirect_PC         <= resolve_miss ? correct_pc : 32'd0;
         execute_missPred    <= resolve_miss;
         // Uses the value of last_was_ret before this branch updates it.
         execute_c_r_after_r <= resolve_miss & (ex_isCall | ex_isRet) & last_was_ret_reg;
         execute_isCall      <= resolve_miss & ex_isCall;
      end
   end

   // ------------------------------------------------------------------
   // Update FIFO
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc4[wr_ptr_reg]     <= ex_PC4;
         mem_target[wr_ptr_reg]  <= ex_actual_target;
         mem_dir[wr_ptr_reg]     <= ex_actual_dir;
         mem_miss[wr_ptr_reg]    <= miss;
         mem_bimodal[wr_ptr_reg] <= ex_bimodal;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Head record is presented directly; fields read as zero while empty so
   // stale storage never leaks onto the update port.
   assign execute_bpredictor_update  = ~empty;
   assign execute_bpredictor_PC4     = empty ? 32'd0 : mem_pc4[rd_ptr_reg];
   assign execute_bpredictor_target  = empty ? 32'd0 : mem_target[rd_ptr_reg];
   assign execute_bpredictor_dir     = empty ? 1'b0  : mem_dir[rd_ptr_reg];
   assign execute_bpredictor_miss    = empty ? 1'b0  : mem_miss[rd_ptr_reg];
   assign execute_bpredictor_bimodal = empty ? 12'd0 : mem_bimodal[rd_ptr_reg];

endmodule

// File: doc/bpred_resolve.md
# bpred_resolve

Execute-side branch resolution and predictor update generator. It compares the fetch-time prediction carried down the pipeline with the actual branch outcome computed in execute, and issues a one-cycle redirect on a mispredict. It drives the RAS repair signals and queues bimodal/BTB update records in a small FIFO, so updates are not lost while the predictor is stalled. It is the producer for the predictor's `execute_bpredictor_*` update port.

## Interface
- `DEPTH`, 4: update FIFO entries (power of 2, ≥2).
- `SQUASH_CYCLES`, 2: cycles of wrong-path branches ignored after a redirect (1..15).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `ex_valid`  in  1  execute holds a valid instruction this cycle.
- `ex_isBranch`  in  1  instruction is a control transfer.
- `ex_isCall` / `ex_isRet`  in  1 each  call / return decode.
- `ex_PC4`  in  32  PC+4 of the instruction.
- `ex_actual_dir`  in  1  resolved taken.
- `ex_actual_target`  in  32  resolved target.
- `ex_pred_dir`  in  1  fetch-time predicted direction.
- `ex_pred_target`  in  32  fetch-time predicted target.
- `ex_bimodal`  in  12  fetch-time {index[7:0], counter[1:0], 2'b00}, carried unchanged.
- `soin_bpredictor_stall`  in  1  predictor cannot accept an update this cycle.
- `ex_stall`  out  1  backpressure to execute: FIFO full.
- `redirect_valid`  out  1  one-cycle fetch redirect.
- `redirect_PC`  out  32  correct next PC.
- `execute_missPred`, `execute_c_r_after_r`, `execute_isCall`  out  1 each  RAS repair, one-cycle pulses.
- `execute_bpredictor_update`  out  1  update record valid (FIFO non-empty).
- `execute_bpredictor_PC4`, `execute_bpredictor_target`  out  32 each  head record fields.
- `execute_bpredictor_dir`, `execute_bpredictor_miss`  out  1 each  head record fields.
- `execute_bpredictor_bimodal`  out  12  head record field.

## Operation
- Resolve when `ex_valid & ex_isBranch & ~squashing & ~ex_stall`.
- miss = (pred_dir != actual_dir) | (actual_dir & pred_target != actual_target).
- Correct PC = actual_dir ? actual_target : ex_PC4.
- On a resolving miss:
  - Register `redirect_valid`=1, `redirect_PC`, `execute_missPred`=1, `execute_isCall`=ex_isCall.
  - `execute_c_r_after_r` = (ex_isCall | ex_isRet) & last_was_ret.
  - Enter SQUASH.
- last_was_ret: updated on every resolved branch to ex_isRet. Squashed branches do not touch it.
- States:
  - IDLE → SQUASH on a resolving miss; counter loads SQUASH_CYCLES.
  - SQUASH: decrement each cycle; return to IDLE when the counter reaches 0.
  - Branches arriving in SQUASH are dropped: no enqueue, no redirect, no state change.
  - A miss cannot occur in SQUASH, because those branches are dropped.
- Enqueue every resolved branch (hit or miss). Record = {PC4, actual_target, actual_dir, miss, bimodal}.
- Dequeue when `~soin_bpredictor_stall & ~empty`. Update outputs always show the head record.
- Push and pop in the same cycle: occupancy unchanged. When empty, the pushed record becomes head next cycle.
- `ex_stall` = full (combinational from occupancy). No push while full, even if a pop occurs that cycle.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.

## Timing
- Reset (async assert, sync-released on clk):
  - All outputs 0, FIFO empty, state IDLE, last_was_ret 0, squash counter 0.
- Redirect and RAS pulses: exactly one cycle, registered, asserted in the cycle after the resolving edge.
- Update latency:
  - A branch resolved at edge N appears at the head no earlier than after edge N, provided it arrives empty or becomes head then.
  - It stays valid until the first edge with stall=0.
- Squash window: the SQUASH_CYCLES cycles following the redirect edge. A branch in the cycle after that window resolves normally.
- reset_n asserted mid-operation discards FIFO contents and any pending squash immediately.

## Test plan
- Correct prediction: taken branch, PC4=0x104, pred/actual target 0x200, dir 1/1 → no redirect. One cycle later: update=1, miss=0, dir=1, target=0x200, PC4=0x104.
- Direction miss: pred 0, actual 1, target 0x300.
  - Next cycle: redirect_valid=1, redirect_PC=0x300, missPred=1.
  - Branches in the next 2 cycles are dropped; the FIFO holds one record with miss=1.
- Return then call mispredict: return resolved with a hit, then a call mispredicted → c_r_after_r=1, isCall=1 pulse for one cycle.
- Stall backpressure: stall=1 held while 4 branches are resolved → ex_stall=1 after the 4th. A 5th branch is held. Release stall → records drain in order, one per cycle.
- Simultaneous push/pop with 2 entries and stall=0 → occupancy stays 2, order preserved across pointer wrap.
- reset_n pulsed low mid-squash with 3 queued records → update=0, redirect=0 immediately. The first branch after release resolves normally.
